uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Self-timed UART receiver for 8N1 frames, the receive counterpart of the team's UART transmitter path.
- Synchronises the asynchronous rx pin and detects the start bit.
- Generates its own baud timing and samples each bit at mid-bit.
- Delivers each byte as po_data with a one-cycle po_flag strobe, which feeds the transmitter loopback and the SPI command paths directly.
- Reports stop-bit failures on frame_err.

Parameters:
BAUD_CNT_MAX, 5208, sclk cycles per bit (50 MHz / 9600); legal range is 8 or more.
BAUD_CNT_HALF, BAUD_CNT_MAX/2, baud_cnt value at which a bit is sampled; derived, do not override.

Ports:
sclk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous, idle high
po_data  output  8  last correctly received byte, LSB received first
po_flag  output  1  one-cycle strobe, po_data valid
frame_err  output  1  one-cycle strobe, stop bit sampled low
rx_busy  output  1  high while a frame is being received

Behaviour:
- Reset: rst_n is asynchronous, active-low; the clock is sclk. During and after reset, all state holds these values:
  - po_data = 8'h00, po_flag = 0, frame_err = 0, rx_busy = 0.
  - baud_cnt = 0, bit_cnt = 0.
  - All synchroniser flops = 1, so there is no false start out of reset.
- Synchroniser: rx passes through flops rx_d1 and rx_d2, plus rx_d3 for edge detection. All decisions use rx_d2 and rx_d3 only.
- Start detect: when rx_busy = 0 and rx_d3 = 1 and rx_d2 = 0, rx_busy goes to 1 on the next edge; baud_cnt and bit_cnt are 0. Edges are ignored while rx_busy = 1.
- Baud counter:
  - While rx_busy = 1, baud_cnt counts 0 .. BAUD_CNT_MAX-1 and then wraps to 0.
  - bit_cnt increments on each wrap.
  - Both counters are held at 0 while rx_busy = 0.
- Sample strobe: bit_flag = (rx_busy && baud_cnt == BAUD_CNT_HALF), an internal combinational signal. On bit_flag, action depends on bit_cnt:
  - bit_cnt 0 (start bit): if rx_d2 = 1, this is a false start; rx_busy clears on the next edge and there is no output strobe.
  - bit_cnt 1..8: shift_reg[bit_cnt-1] <= rx_d2.
  - bit_cnt 9 (stop bit):
    - If rx_d2 = 1: po_data <= shift_reg and po_flag <= 1.
    - If rx_d2 = 0: frame_err <= 1 and po_data is unchanged.
    - In both cases rx_busy <= 0 and the counters clear.
- Strobes: po_flag and frame_err are high for exactly one cycle, in the cycle after the stop-bit bit_flag. They are never high together.
- Latency: po_flag rises about 9.5 bit times plus 4 sclk after the rx falling edge at the pin.
- Back-to-back frames: the receiver returns to idle at mid-stop-bit, so a start edge arriving at the end of the stop bit is caught with no lost frame.
- Break (rx held low): produces one frame_err. Because no new falling edge occurs, there is no re-trigger until rx returns high and falls again.
- Reset mid-frame: the partial byte is discarded, there are no strobes, and the receiver returns to idle immediately.
- Glitch handling: a low pulse shorter than BAUD_CNT_HALF cycles is rejected by the start-bit check.
- po_data holds its value between frames. The internal shift_reg is never visible on po_data until the stop bit is validated.

Test Plan (BAUD_CNT_MAX = 16 for simulation):
- Single frame 0x55 with correct stop bit -> one po_flag pulse, po_data = 8'h55, frame_err = 0, rx_busy low after the strobe.
- Back-to-back 0xA3, 0x00, 0xFF with no idle gap -> three po_flag pulses carrying 8'hA3, 8'h00, 8'hFF in order, no frame_err.
- 4-cycle low glitch on an idle line -> rx_busy pulses then clears at the start sample, no po_flag, no frame_err, po_data unchanged.
- Frame 0x3C with stop bit driven 0 -> frame_err pulses once, no po_flag, po_data keeps its previous value (8'hFF from the prior test).
- rst_n asserted during data bit 4 of 0x81, released, then a clean 0x81 sent -> no strobe for the aborted frame; the clean frame yields po_data = 8'h81.
- rx held low for 30 bit times, then high, then frame 0x7E -> exactly one frame_err during the break, then po_flag with po_data = 8'h7E.

Source files
------------

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : Self-timed 8N1 UART receiver. Synchronises the rx pin, detects
//            the start edge, times each bit from sclk and samples it at
//            mid-bit. Each good byte is presented on po_data with a one-cycle
//            po_flag strobe; a low stop bit gives a one-cycle frame_err.
// Ports    : sclk      - system clock
//            rst_n     - asynchronous active-low reset
//            rx        - serial line, asynchronous, idle high
//            po_data   - last correctly received byte (LSB first on the line)
//            po_flag   - one-cycle strobe, po_data valid
//            frame_err - one-cycle strobe, stop bit sampled low
//            rx_busy   - high while a frame is being received
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int BAUD_CNT_MAX = 5208
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       rx_busy
);

    // Mid-bit sample point, derived from the bit period.
    localparam int BAUD_CNT_HALF = BAUD_CNT_MAX / 2;

    localparam int              c_CNT_W    = $clog2(BAUD_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(BAUD_CNT_HALF);
    localparam logic [3:0]      c_BIT_START = 4'd0;
    localparam logic [3:0]      c_BIT_STOP  = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_rx_d1;
    logic                 r_rx_d2;
    logic                 r_rx_d3;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [3:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_po_data;
    logic                 r_po_flag;
    logic                 r_frame_err;

    logic                 w_start;
    logic                 w_bit_flag;
    logic                 w_false_start;
    logic                 w_stop_sample;
    logic                 w_data_sample;
    logic                 w_po_flag_nxt;
    logic                 w_frame_err_nxt;
    logic [2:0]           w_shift_idx;

    // ------------------------------------------------------------------------
    // Input synchroniser. Flops reset high so a line that is idle (high)
    // out of reset cannot look like a falling edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_d1 <= 1'b1;
            r_rx_d2 <= 1'b1;
            r_rx_d3 <= 1'b1;
        end else begin
            r_rx_d1 <= rx;
            r_rx_d2 <= r_rx_d1;
            r_rx_d3 <= r_rx_d2;
        end
    end

    // ------------------------------------------------------------------------
    // Decode of the current sample point
    // ------------------------------------------------------------------------
    assign w_start         = (r_state == ST_IDLE) && r_rx_d3 && !r_rx_d2;
    assign w_bit_flag      = (r_state == ST_RECV) && (r_baud_cnt == c_CNT_MID);
    assign w_false_start   = w_bit_flag && (r_bit_cnt == c_BIT_START) && r_rx_d2;
    assign w_stop_sample   = w_bit_flag && (r_bit_cnt == c_BIT_STOP);
    assign w_data_sample   = w_bit_flag && (r_bit_cnt != c_BIT_START)
                                        && (r_bit_cnt != c_BIT_STOP);
    assign w_po_flag_nxt   = w_stop_sample &&  r_rx_d2;
    assign w_frame_err_nxt = w_stop_sample && !r_rx_d2;
    // bit_cnt 1..8 maps to shift positions 0..7; the 3-bit wrap turns 8 into 7.
    assign w_shift_idx     = r_bit_cnt[2:0] - 3'd1;

    // ------------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM: next state. Returning to idle at mid-stop-bit leaves half a
    // bit of margin to catch a back-to-back start edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_false_start || w_stop_sample) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Baud and bit counters: run only while receiving, cleared on leaving.
    // ------------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if ((r_state != ST_RECV) || (w_state_nxt != ST_RECV)) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (r_baud_cnt == c_CNT_LAST) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Data capture. The shift register stays internal; po_data only updates
    // once the stop bit has been validated.
    // ------------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (w_data_sample) begin
            r_shift[w_shift_idx] <= r_rx_d2;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_po_data   <= '0;
            r_po_flag   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_po_flag   <= w_po_flag_nxt;
            r_frame_err <= w_frame_err_nxt;
            if (w_po_flag_nxt) begin
                r_po_data <= r_shift;
            end
        end
    end

    assign po_data   = r_po_data;
    assign po_flag   = r_po_flag;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state == ST_RECV);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Self-checking bench for uart_rx_frame with a 16-cycle bit time.
//            Stimulus pushes the expected strobe (byte or frame error) into a
//            queue; a monitor pops and compares on every po_flag / frame_err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int c_BIT = 16;

    logic       sclk;
    logic       rst_n;
    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;
    logic       rx_busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp;
    int   n_fail;

    uart_rx_frame #(
        .BAUD_CNT_MAX (c_BIT)
    ) u_dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .rx        (rx),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        wait_cyc(c_BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(c_BIT);
        end
        rx = stop;
        wait_cyc(c_BIT);
        rx = 1'b1;
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        q_exp.push_back(e);
    endtask

    task automatic expect_err(input logic [7:0] held);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = held;
        q_exp.push_back(e);
    endtask

    // Monitor: every strobe cycle must match the head of the queue.
    always @(negedge sclk) begin
        if (rst_n === 1'b1) begin
            if (po_flag && frame_err) begin
                check("strobes_together", 32'(po_flag & frame_err), 32'd0);
            end
            if (po_flag || frame_err) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_strobe", {30'd0, po_flag, frame_err}, 32'd0);
                end else begin
                    automatic exp_t e = q_exp.pop_front();
                    check("strobe_kind", 32'(frame_err), 32'(e.is_err));
                    check("po_data", 32'(po_data), 32'(e.data));
                    check("busy_after_strobe", 32'(rx_busy), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rx     = 1'b1;
        rst_n  = 1'b0;
        wait_cyc(4);
        check("rst_po_data",   32'(po_data),   32'h00);
        check("rst_po_flag",   32'(po_flag),   32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_rx_busy",   32'(rx_busy),   32'd0);
        rst_n = 1'b1;
        wait_cyc(8);
        check("idle_busy", 32'(rx_busy), 32'd0);

        // Single good frame
        expect_byte(8'h55);
        send_frame(8'h55, 1'b1);
        wait_cyc(8);
        check("t1_busy_low", 32'(rx_busy), 32'd0);
        check("t1_data_held", 32'(po_data), 32'h55);

        // Back-to-back frames, no idle gap
        expect_byte(8'hA3);
        send_frame(8'hA3, 1'b1);
        expect_byte(8'h00);
        send_frame(8'h00, 1'b1);
        expect_byte(8'hFF);
        send_frame(8'hFF, 1'b1);
        wait_cyc(c_BIT);

        // 4-cycle glitch: start detected, rejected at the mid-start sample
        rx = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(2);
        check("glitch_busy_high", 32'(rx_busy), 32'd1);
        wait_cyc(10);
        check("glitch_busy_clear", 32'(rx_busy), 32'd0);
        check("glitch_data_held", 32'(po_data), 32'hFF);
        wait_cyc(c_BIT);

        // Bad stop bit: frame error, po_data keeps 0xFF
        expect_err(8'hFF);
        send_frame(8'h3C, 1'b0);
        wait_cyc(c_BIT);
        check("ferr_data_held", 32'(po_data), 32'hFF);

        // Reset during data bit 4 of 0x81
        rx = 1'b0;
        wait_cyc(c_BIT);
        rx = 1'b1;
        wait_cyc(c_BIT);
        rx = 1'b0;
        wait_cyc(3 * c_BIT + c_BIT / 2);
        check("abort_busy_before_rst", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cyc(3);
        check("abort_rst_data", 32'(po_data), 32'h00);
        check("abort_rst_busy", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;
        wait_cyc(2 * c_BIT);
        check("abort_idle_busy", 32'(rx_busy), 32'd0);
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1);
        wait_cyc(c_BIT);

        // Break: 30 bit times low gives exactly one frame error
        expect_err(8'h81);
        rx = 1'b0;
        wait_cyc(30 * c_BIT);
        check("break_no_retrigger", 32'(rx_busy), 32'd0);
        rx = 1'b1;
        wait_cyc(2 * c_BIT);
        expect_byte(8'h7E);
        send_frame(8'h7E, 1'b1);

        // Drain: every expected strobe must have been seen
        wait_cyc(4 * c_BIT);
        check("queue_drained", 32'(q_exp.size()), 32'd0);
        check("final_data", 32'(po_data), 32'h7E);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
